// File: rtl/rtsnoc_local_port_buffer.sv
// Elastic TX/RX flit buffers between the RTSNoC bus slave and a router local port.
// Each direction is a power-of-two circular FIFO with first-word fall-through output.

module rtsnoc_lpb_fifo #(
  parameter int DW         = 38,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  push_i,
  input  logic [DW-1:0]         wdata_i,
  input  logic                  pop_i,
  output logic [DW-1:0]         rdata_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DW-1:0]         mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  // Level never exceeds DEPTH, so its MSB alone marks the full state.
  assign full_o  = level_o[DEPTH_LOG2];
  assign empty_o = (level_o == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = empty_o ? '0 : mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_o <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_o <= level_o + (DEPTH_LOG2 + 1)'(1);
        2'b01:   level_o <= level_o - (DEPTH_LOG2 + 1)'(1);
        default: level_o <= level_o;
      endcase
    end
  end

  // NOTE: the storage array is not reset; empty gating on rdata_o hides stale entries.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= wdata_i;
  end

endmodule

module rtsnoc_local_port_buffer #(
  parameter int DATA_WIDTH    = 38,
  parameter int TX_DEPTH_LOG2 = 2,
  parameter int RX_DEPTH_LOG2 = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [DATA_WIDTH-1:0]   core_din_i,
  input  logic                    core_wr_i,
  output logic                    core_wait_o,
  output logic [DATA_WIDTH-1:0]   core_dout_o,
  output logic                    core_nd_o,
  input  logic                    core_rd_i,
  output logic [DATA_WIDTH-1:0]   rtr_din_o,
  output logic                    rtr_wr_o,
  input  logic                    rtr_wait_i,
  input  logic [DATA_WIDTH-1:0]   rtr_dout_i,
  input  logic                    rtr_nd_i,
  output logic                    rtr_rd_o,
  output logic [TX_DEPTH_LOG2:0]  tx_level_o,
  output logic [RX_DEPTH_LOG2:0]  rx_level_o,
  output logic                    ovf_o
);

  logic tx_empty;
  logic tx_full;
  logic rx_empty;
  logic rx_full;
  logic tx_push;
  logic tx_pop;
  logic rx_pop;

  assign tx_push     = core_wr_i && !tx_full;
  assign tx_pop      = !tx_empty && !rtr_wait_i;
  assign rx_pop      = core_rd_i && !rx_empty;
  // Gated by reset so no router flit is consumed while the buffer is held in reset.
  assign rtr_rd_o    = rtr_nd_i && !rx_full && rst_n_i;

  assign core_wait_o = tx_full;
  assign rtr_wr_o    = !tx_empty;
  assign core_nd_o   = !rx_empty;

  rtsnoc_lpb_fifo #(
    .DW         (DATA_WIDTH),
    .DEPTH_LOG2 (TX_DEPTH_LOG2)
  ) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (tx_push),
    .wdata_i (core_din_i),
    .pop_i   (tx_pop),
    .rdata_o (rtr_din_o),
    .level_o (tx_level_o),
    .empty_o (tx_empty),
    .full_o  (tx_full)
  );

  rtsnoc_lpb_fifo #(
    .DW         (DATA_WIDTH),
    .DEPTH_LOG2 (RX_DEPTH_LOG2)
  ) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (rtr_rd_o),
    .wdata_i (rtr_dout_i),
    .pop_i   (rx_pop),
    .rdata_o (core_dout_o),
    .level_o (rx_level_o),
    .empty_o (rx_empty),
    .full_o  (rx_full)
  );

  // A write against a full TX FIFO is dropped even if the router pops on the same edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) ovf_o <= 1'b0;
    else          ovf_o <= core_wr_i && tx_full;
  end

endmodule

// File: tb/tb_rtsnoc_local_port_buffer.sv
// Directed bench for rtsnoc_local_port_buffer: vector table for FIFO fill/drain,
// plus hand-written streaming and mid-operation reset sequences.

module tb_rtsnoc_local_port_buffer;

  typedef struct packed {
    logic        core_wr;
    logic [37:0] core_din;
    logic        core_rd;
    logic        rtr_wait;
    logic        rtr_nd;
    logic [37:0] rtr_dout;
  } in_t;

  typedef struct packed {
    logic        core_wait;
    logic        core_nd;
    logic [37:0] core_dout;
    logic        rtr_wr;
    logic [37:0] rtr_din;
    logic        rtr_rd;
    logic [2:0]  tx_level;
    logic [2:0]  rx_level;
    logic        ovf;
  } out_t;

  typedef struct {
    string name;
    in_t   stim;
    out_t  exp;
  } vec_t;

  localparam logic [37:0] Z  = 38'h0;
  localparam logic [37:0] F1 = 38'h15_0000_0001;
  localparam logic [37:0] F2 = 38'h15_0000_0002;
  localparam logic [37:0] F3 = 38'h15_0000_0003;
  localparam logic [37:0] F4 = 38'h15_0000_0004;
  localparam logic [37:0] F5 = 38'h15_0000_0005;
  localparam logic [37:0] G1 = 38'h2A_1234_0001;
  localparam logic [37:0] G2 = 38'h2A_1234_0002;
  localparam logic [37:0] G3 = 38'h2A_1234_0003;
  localparam logic [37:0] G4 = 38'h2A_1234_0004;
  localparam logic [37:0] G5 = 38'h2A_1234_0005;
  localparam logic [37:0] G6 = 38'h2A_1234_0006;
  localparam logic [37:0] H1 = 38'h0B_BEEF_0001;
  localparam logic [37:0] H2 = 38'h0B_BEEF_0002;
  localparam logic [37:0] H3 = 38'h0B_BEEF_0003;
  localparam logic [37:0] G7 = 38'h2A_1234_0007;
  localparam logic [37:0] G8 = 38'h2A_1234_0008;
  localparam logic [37:0] G9 = 38'h2A_1234_0009;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [37:0] core_din_i;
  logic        core_wr_i;
  logic        core_wait_o;
  logic [37:0] core_dout_o;
  logic        core_nd_o;
  logic        core_rd_i;
  logic [37:0] rtr_din_o;
  logic        rtr_wr_o;
  logic        rtr_wait_i;
  logic [37:0] rtr_dout_i;
  logic        rtr_nd_i;
  logic        rtr_rd_o;
  logic [2:0]  tx_level_o;
  logic [2:0]  rx_level_o;
  logic        ovf_o;

  int   n_tests = 0;
  int   n_fail  = 0;
  out_t act;
  vec_t vecs [$];

  always #5 clk_i = ~clk_i;

  rtsnoc_local_port_buffer dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .core_din_i  (core_din_i),
    .core_wr_i   (core_wr_i),
    .core_wait_o (core_wait_o),
    .core_dout_o (core_dout_o),
    .core_nd_o   (core_nd_o),
    .core_rd_i   (core_rd_i),
    .rtr_din_o   (rtr_din_o),
    .rtr_wr_o    (rtr_wr_o),
    .rtr_wait_i  (rtr_wait_i),
    .rtr_dout_i  (rtr_dout_i),
    .rtr_nd_i    (rtr_nd_i),
    .rtr_rd_o    (rtr_rd_o),
    .tx_level_o  (tx_level_o),
    .rx_level_o  (rx_level_o),
    .ovf_o       (ovf_o)
  );

  assign act = '{core_wait: core_wait_o, core_nd: core_nd_o, core_dout: core_dout_o,
                 rtr_wr: rtr_wr_o, rtr_din: rtr_din_o, rtr_rd: rtr_rd_o,
                 tx_level: tx_level_o, rx_level: rx_level_o, ovf: ovf_o};

  function automatic in_t mk_in(logic wr, logic [37:0] din, logic rd, logic rwait,
                                logic nd, logic [37:0] rdout);
    mk_in = '{core_wr: wr, core_din: din, core_rd: rd, rtr_wait: rwait,
              rtr_nd: nd, rtr_dout: rdout};
  endfunction

  function automatic out_t mk_out(logic wt, logic nd, logic [37:0] dout, logic rwr,
                                  logic [37:0] rdin, logic rrd, logic [2:0] txl,
                                  logic [2:0] rxl, logic ovf);
    mk_out = '{core_wait: wt, core_nd: nd, core_dout: dout, rtr_wr: rwr, rtr_din: rdin,
               rtr_rd: rrd, tx_level: txl, rx_level: rxl, ovf: ovf};
  endfunction

  function automatic void add(string name, in_t stim, out_t exp);
    vec_t v;
    v.name = name;
    v.stim = stim;
    v.exp  = exp;
    vecs.push_back(v);
  endfunction

  task automatic drive(input in_t s);
    core_wr_i  = s.core_wr;
    core_din_i = s.core_din;
    core_rd_i  = s.core_rd;
    rtr_wait_i = s.rtr_wait;
    rtr_nd_i   = s.rtr_nd;
    rtr_dout_i = s.rtr_dout;
  endtask

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic check_outs(input string name, input out_t want);
    check(name, 128'(act), 128'(want));
  endtask

  // Drive just after the rising edge, compare on the falling edge.
  task automatic cycle(input in_t s);
    @(posedge clk_i);
    #1;
    drive(s);
    @(negedge clk_i);
  endtask

  initial begin
    out_t zero;
    zero = mk_out(1'b0, 1'b0, Z, 1'b0, Z, 1'b0, 3'd0, 3'd0, 1'b0);

    // TX fill with router stalled, overflow, drop-while-full-with-pop, drain
    add("tx_fill0",  mk_in(1'b1, F1, 1'b0, 1'b1, 1'b0, Z), mk_out(1'b0, 1'b0, Z, 1'b0, Z,  1'b0, 3'd0, 3'd0, 1'b0));
    add("tx_fill1",  mk_in(1'b1, F2, 1'b0, 1'b1, 1'b0, Z), mk_out(1'b0, 1'b0, Z, 1'b1, F1, 1'b0, 3'd1, 3'd0, 1'b0));
    add("tx_fill2",  mk_in(1'b1, F3, 1'b0, 1'b1, 1'b0, Z), mk_out(1'b0, 1'b0, Z, 1'b1, F1, 1'b0, 3'd2, 3'd0, 1'b0));
    add("tx_fill3",  mk_in(1'b1, F4, 1'b0, 1'b1, 1'b0, Z), mk_out(1'b0, 1'b0, Z, 1'b1, F1, 1'b0, 3'd3, 3'd0, 1'b0));
    add("tx_full",   mk_in(1'b1, F5, 1'b0, 1'b1, 1'b0, Z), mk_out(1'b1, 1'b0, Z, 1'b1, F1, 1'b0, 3'd4, 3'd0, 1'b0));
    add("tx_ovf",    mk_in(1'b0, Z,  1'b0, 1'b1, 1'b0, Z), mk_out(1'b1, 1'b0, Z, 1'b1, F1, 1'b0, 3'd4, 3'd0, 1'b1));
    add("tx_wr_pop", mk_in(1'b1, F5, 1'b0, 1'b0, 1'b0, Z), mk_out(1'b1, 1'b0, Z, 1'b1, F1, 1'b0, 3'd4, 3'd0, 1'b0));
    add("tx_drain1", mk_in(1'b0, Z,  1'b0, 1'b0, 1'b0, Z), mk_out(1'b0, 1'b0, Z, 1'b1, F2, 1'b0, 3'd3, 3'd0, 1'b1));
    add("tx_drain2", mk_in(1'b0, Z,  1'b0, 1'b0, 1'b0, Z), mk_out(1'b0, 1'b0, Z, 1'b1, F3, 1'b0, 3'd2, 3'd0, 1'b0));
    add("tx_drain3", mk_in(1'b0, Z,  1'b0, 1'b0, 1'b0, Z), mk_out(1'b0, 1'b0, Z, 1'b1, F4, 1'b0, 3'd1, 3'd0, 1'b0));
    add("tx_empty",  mk_in(1'b0, Z,  1'b0, 1'b0, 1'b0, Z), mk_out(1'b0, 1'b0, Z, 1'b0, Z,  1'b0, 3'd0, 3'd0, 1'b0));
    // RX: router offers 5 flits, core stalled; then pop, re-accept, push+pop at level 2, empty reads
    add("rx_acc1",   mk_in(1'b0, Z, 1'b0, 1'b0, 1'b1, G1), mk_out(1'b0, 1'b0, Z,  1'b0, Z, 1'b1, 3'd0, 3'd0, 1'b0));
    add("rx_acc2",   mk_in(1'b0, Z, 1'b0, 1'b0, 1'b1, G2), mk_out(1'b0, 1'b1, G1, 1'b0, Z, 1'b1, 3'd0, 3'd1, 1'b0));
    add("rx_acc3",   mk_in(1'b0, Z, 1'b0, 1'b0, 1'b1, G3), mk_out(1'b0, 1'b1, G1, 1'b0, Z, 1'b1, 3'd0, 3'd2, 1'b0));
    add("rx_acc4",   mk_in(1'b0, Z, 1'b0, 1'b0, 1'b1, G4), mk_out(1'b0, 1'b1, G1, 1'b0, Z, 1'b1, 3'd0, 3'd3, 1'b0));
    add("rx_full",   mk_in(1'b0, Z, 1'b0, 1'b0, 1'b1, G5), mk_out(1'b0, 1'b1, G1, 1'b0, Z, 1'b0, 3'd0, 3'd4, 1'b0));
    add("rx_hold",   mk_in(1'b0, Z, 1'b0, 1'b0, 1'b1, G5), mk_out(1'b0, 1'b1, G1, 1'b0, Z, 1'b0, 3'd0, 3'd4, 1'b0));
    add("rx_popful", mk_in(1'b0, Z, 1'b1, 1'b0, 1'b1, G5), mk_out(1'b0, 1'b1, G1, 1'b0, Z, 1'b0, 3'd0, 3'd4, 1'b0));
    add("rx_reacc",  mk_in(1'b0, Z, 1'b0, 1'b0, 1'b1, G5), mk_out(1'b0, 1'b1, G2, 1'b0, Z, 1'b1, 3'd0, 3'd3, 1'b0));
    add("rx_full2",  mk_in(1'b0, Z, 1'b0, 1'b0, 1'b0, Z),  mk_out(1'b0, 1'b1, G2, 1'b0, Z, 1'b0, 3'd0, 3'd4, 1'b0));
    add("rx_pop_a",  mk_in(1'b0, Z, 1'b1, 1'b0, 1'b0, Z),  mk_out(1'b0, 1'b1, G2, 1'b0, Z, 1'b0, 3'd0, 3'd4, 1'b0));
    add("rx_pop_b",  mk_in(1'b0, Z, 1'b1, 1'b0, 1'b0, Z),  mk_out(1'b0, 1'b1, G3, 1'b0, Z, 1'b0, 3'd0, 3'd3, 1'b0));
    add("rx_pushpop",mk_in(1'b0, Z, 1'b1, 1'b0, 1'b1, G6), mk_out(1'b0, 1'b1, G4, 1'b0, Z, 1'b1, 3'd0, 3'd2, 1'b0));
    add("rx_after",  mk_in(1'b0, Z, 1'b0, 1'b0, 1'b0, Z),  mk_out(1'b0, 1'b1, G5, 1'b0, Z, 1'b0, 3'd0, 3'd2, 1'b0));
    add("rx_drain1", mk_in(1'b0, Z, 1'b1, 1'b0, 1'b0, Z),  mk_out(1'b0, 1'b1, G5, 1'b0, Z, 1'b0, 3'd0, 3'd2, 1'b0));
    add("rx_drain2", mk_in(1'b0, Z, 1'b1, 1'b0, 1'b0, Z),  mk_out(1'b0, 1'b1, G6, 1'b0, Z, 1'b0, 3'd0, 3'd1, 1'b0));
    add("rx_emp_rd", mk_in(1'b0, Z, 1'b1, 1'b0, 1'b0, Z),  mk_out(1'b0, 1'b0, Z,  1'b0, Z, 1'b0, 3'd0, 3'd0, 1'b0));
    add("rx_emp_rd2",mk_in(1'b0, Z, 1'b1, 1'b0, 1'b0, Z),  mk_out(1'b0, 1'b0, Z,  1'b0, Z, 1'b0, 3'd0, 3'd0, 1'b0));

    // Power-on reset with the router already offering a flit
    rst_n_i = 1'b0;
    drive(mk_in(1'b1, F1, 1'b1, 1'b0, 1'b1, G1));
    #1;
    check_outs("por_async", zero);
    repeat (2) @(posedge clk_i);
    #1;
    check_outs("por_held", zero);
    @(negedge clk_i);
    drive(mk_in(1'b0, Z, 1'b0, 1'b0, 1'b0, Z));
    rst_n_i = 1'b1;
    @(negedge clk_i);
    check_outs("por_release", zero);

    foreach (vecs[k]) begin
      cycle(vecs[k].stim);
      check_outs(vecs[k].name, vecs[k].exp);
    end

    // Full-rate TX streaming across several pointer wraps
    for (int i = 0; i < 20; i++) begin
      cycle(mk_in(1'b1, 38'h3F_0000_0000 + 38'(i), 1'b0, 1'b0, 1'b0, Z));
      if (i == 0)
        check_outs("stream_first", zero);
      else
        check_outs($sformatf("stream_%0d", i),
                   mk_out(1'b0, 1'b0, Z, 1'b1, 38'h3F_0000_0000 + 38'(i - 1), 1'b0, 3'd1, 3'd0, 1'b0));
    end
    cycle(mk_in(1'b0, Z, 1'b0, 1'b0, 1'b0, Z));
    check_outs("stream_last", mk_out(1'b0, 1'b0, Z, 1'b1, 38'h3F_0000_0013, 1'b0, 3'd1, 3'd0, 1'b0));
    cycle(mk_in(1'b0, Z, 1'b0, 1'b0, 1'b0, Z));
    check_outs("stream_done", zero);

    // Build TX=3, RX=2, then reset in the middle of a cycle
    cycle(mk_in(1'b1, H1, 1'b0, 1'b1, 1'b1, G7));
    check_outs("mid_load0", mk_out(1'b0, 1'b0, Z, 1'b0, Z, 1'b1, 3'd0, 3'd0, 1'b0));
    cycle(mk_in(1'b1, H2, 1'b0, 1'b1, 1'b1, G8));
    cycle(mk_in(1'b1, H3, 1'b0, 1'b1, 1'b0, Z));
    cycle(mk_in(1'b0, Z, 1'b0, 1'b1, 1'b1, G9));
    check_outs("mid_loaded", mk_out(1'b0, 1'b1, G7, 1'b1, H1, 1'b1, 3'd3, 3'd2, 1'b0));
    #2;
    rst_n_i = 1'b0;
    #1;
    check_outs("mid_rst_async", zero);
    @(posedge clk_i);
    #1;
    check_outs("mid_rst_held", zero);
    @(negedge clk_i);
    drive(mk_in(1'b0, Z, 1'b0, 1'b0, 1'b0, Z));
    rst_n_i = 1'b1;
    @(negedge clk_i);
    check_outs("mid_rst_after", zero);
    cycle(mk_in(1'b0, Z, 1'b1, 1'b0, 1'b0, Z));
    check_outs("post_rst_emp_rd", zero);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rtsnoc_local_port_buffer.md
# rtsnoc_local_port_buffer

Elastic buffer between the NoC-side port of the RTSNoC Wishbone/AXI4-lite slave and the local port of an RTSNoC router. Decouples the bus-facing slave from router back-pressure with a TX FIFO (slave → router) and an RX FIFO (router → slave). The slave-facing side uses the same 38-bit `din/wr/wait` and `dout/rd/nd` signalling the slave already drives. Also reports FIFO occupancy and overflow for debug.

## Interface
- `DATA_WIDTH`, 38, NoC flit width (header + 32-bit payload); both directions.
- `TX_DEPTH_LOG2`, 2, log2 of TX FIFO depth (default 4 entries); legal range 1..6.
- `RX_DEPTH_LOG2`, 2, log2 of RX FIFO depth (default 4 entries); legal range 1..6.

- `clk_i` in 1: single clock for all logic.
- `rst_n_i` in 1: asynchronous, active-low reset.
- `core_din_i` in DATA_WIDTH: flit from slave to transmit.
- `core_wr_i` in 1: push `core_din_i` into TX FIFO.
- `core_wait_o` out 1: TX FIFO full.
- `core_dout_o` out DATA_WIDTH: RX FIFO head, first-word fall-through; 0 when RX empty.
- `core_nd_o` out 1: RX FIFO not empty.
- `core_rd_i` in 1: pop RX head.
- `rtr_din_o` out DATA_WIDTH: TX FIFO head to router; 0 when TX empty.
- `rtr_wr_o` out 1: TX head valid (TX not empty).
- `rtr_wait_i` in 1: router cannot accept this cycle.
- `rtr_dout_i` in DATA_WIDTH: flit offered by router.
- `rtr_nd_i` in 1: router has a flit on `rtr_dout_i`.
- `rtr_rd_o` out 1: flit on `rtr_dout_i` taken this cycle.
- `tx_level_o` out TX_DEPTH_LOG2+1: TX occupancy.
- `rx_level_o` out RX_DEPTH_LOG2+1: RX occupancy.
- `ovf_o` out 1: one-cycle pulse when a `core_wr_i` is dropped because TX is full.

## Operation
- Each FIFO is a circular buffer with read/write pointers of DEPTH_LOG2 bits, wrapping modulo depth, plus an occupancy counter of DEPTH_LOG2+1 bits. Full is level == 2^DEPTH_LOG2. Empty is level == 0.
- TX push: `core_wr_i && !core_wait_o`. A write while full is discarded; `ovf_o`=1 in the following cycle. A simultaneous router pop does not rescue a write issued while full.
- TX pop: `rtr_wr_o && !rtr_wait_i`. The head advances at the clock edge.
- RX accept: `rtr_rd_o = rtr_nd_i && !rx_full && rst_n_i`. This is combinational. `rtr_dout_i` is written into RX on the same edge, and the router presents its next flit (or drops `rtr_nd_i`) the following cycle.
- RX pop: `core_rd_i && core_nd_o`. `core_rd_i` while empty is ignored; no pointer or level change.
- Simultaneous push and pop on one FIFO: both take effect and the level is unchanged. When full, only the pop takes effect for TX. For RX, `rtr_rd_o` is already low when full.
- No reordering; flits leave each FIFO in arrival order. No header interpretation.

## Timing
- Reset (async assert, sync-safe release): all pointers and levels are 0. Outputs during and after reset: `core_wait_o`=0, `core_nd_o`=0, `core_dout_o`=0, `rtr_wr_o`=0, `rtr_din_o`=0, `rtr_rd_o`=0, `tx_level_o`=0, `rx_level_o`=0, `ovf_o`=0.
- Reset mid-operation discards all buffered flits. `rtr_rd_o` is forced low while `rst_n_i`=0, so no router flit is consumed during reset.
- Latency: a flit pushed at edge N is visible on `rtr_din_o`/`rtr_wr_o` (or `core_dout_o`/`core_nd_o`) after edge N, i.e. one cycle through an empty FIFO.
- Throughput: one flit per cycle per direction when not back-pressured.
- `core_wait_o`, `core_nd_o`, `rtr_wr_o`, the levels and `ovf_o` are derived from registers only. `rtr_rd_o` is the only output with a combinational input path.
- Full-to-not-full: `core_wait_o` drops the cycle after the pop edge.

## Test plan
- Reset, then push 0x15_0000_0001..0x15_0000_0004 with `rtr_wait_i`=1. Required: `tx_level_o`=4 and `core_wait_o`=1 after the 4th edge. A 5th write gives `ovf_o`=1 for one cycle, level stays 4. Release wait: router sees the 4 flits in order on consecutive cycles.
- Router offers 5 flits with `core_rd_i`=0. Required: `rtr_rd_o` high for 4 cycles then low, `rx_level_o`=4. Pop one: `rtr_rd_o` reasserts, and the 5th flit is captured the next cycle.
- Streaming at full rate with `core_wr_i`=1 continuously and `rtr_wait_i`=0. Required: `tx_level_o` stays 1 and the output sequence equals the input sequence with a 1-cycle lag. Pointer wrap is exercised over 20 flits.
- Simultaneous push and pop on RX with level 2. Required: level stays 2 and `core_dout_o` advances to the next flit.
- Assert `rst_n_i`=0 mid-stream with TX=3 and RX=2. Required: all outputs 0 immediately, `rtr_rd_o`=0 despite `rtr_nd_i`=1, and both levels 0 after release.
- `core_rd_i`=1 while RX is empty. Required: no change, `rx_level_o`=0, `core_dout_o`=0.
